// File: rtl/sequence_detector_101_pkg.sv
// Shared state encoding and mode constants for the 1-0-1 serial pattern detector.
package sequence_detector_101_pkg;

    typedef enum logic [1:0] {
        S0   = 2'b00,
        S1   = 2'b01,
        S10  = 2'b10,
        S101 = 2'b11
    } state_t;

    localparam logic [1:0] MOORE_OV  = 2'b00;
    localparam logic [1:0] MOORE_NOV = 2'b01;
    localparam logic [1:0] MEALY_OV  = 2'b10;
    localparam logic [1:0] MEALY_NOV = 2'b11;

    function automatic logic is_mealy(input logic [1:0] m);
        return m[1];
    endfunction

endpackage

// File: rtl/sequence_detector_101.sv
// Detects the serial pattern 1-0-1 in Moore/Mealy, overlapping/non-overlapping modes.
// Latency: Moore flags one cycle after the final 1 is sampled; Mealy flags while it is presented.
// Backpressure: none; one bit is consumed every clock.
module sequence_detector_101
    import sequence_detector_101_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       data,
    input  logic [1:0] mode,
    output logic       detected
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] mode_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S0;
            mode_q <= mode;
        end else begin
            state  <= state_nxt;
            mode_q <= mode;
        end
    end

    // A mode change throws away any partial match.
    always_comb begin
        state_nxt = S0;
        if (mode == mode_q) begin
            case (state)
                S0:  state_nxt = data ? S1 : S0;
                S1:  state_nxt = data ? S1 : S10;
                S10: begin
                    if (!data)
                        state_nxt = S0;
                    else if (!is_mealy(mode))
                        state_nxt = S101;
                    else
                        state_nxt = (mode == MEALY_OV) ? S1 : S0;
                end
                S101: begin
                    if (is_mealy(mode))
                        state_nxt = S0;
                    else if (data)
                        state_nxt = S1;
                    else
                        state_nxt = (mode == MOORE_OV) ? S10 : S0;
                end
                default: state_nxt = S0;
            endcase
        end
    end

    // The Mealy term is suppressed in the cycle a mode change is being applied,
    // since the S10 history it would rely on is being discarded.
    always_comb begin
        detected = 1'b0;
        if (rst) begin
            if (is_mealy(mode))
                detected = (mode == mode_q) && (state == S10) && data;
            else
                detected = (state == S101);
        end
    end

endmodule

// File: tb/tb_sequence_detector_101.sv
// Directed self-checking bench for sequence_detector_101.
module tb_sequence_detector_101;
    import sequence_detector_101_pkg::*;

    logic       clk;
    logic       rst;
    logic       data;
    logic [1:0] mode;
    logic       detected;

    int pass_cnt = 0;
    int total    = 0;

    sequence_detector_101 dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .mode     (mode),
        .detected (detected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic exp);
        total++;
        assert (detected === exp) pass_cnt++;
        else $error("FAIL %s: detected=%b expected=%b", tag, detected, exp);
    endtask

    // Present inputs away from the rising edge, then check before it samples them.
    task automatic step(input logic r, input logic [1:0] m, input logic d,
                        input string tag, input logic exp);
        @(negedge clk);
        rst  = r;
        mode = m;
        data = d;
        #2;
        chk(tag, exp);
    endtask

    // Stream 1,0,1,0,1,0,1,0,1,0,1,0,0; exp_mask bit i = detected while bit i is presented.
    task automatic run_stream(input logic [1:0] m, input logic [13:0] exp_mask,
                              input string name);
        step(1'b0, m, 1'b1, {name, "_reset"}, 1'b0);
        for (int i = 1; i <= 13; i++) begin
            logic b;
            b = (i <= 11) ? logic'(i % 2) : 1'b0;
            step(1'b1, m, b, $sformatf("%s_bit%0d", name, i), exp_mask[i]);
        end
    endtask

    initial begin
        rst  = 1'b0;
        data = 1'b0;
        mode = MOORE_OV;
        repeat (2) @(posedge clk);

        // Moore: pulses when bit after a completed match is presented.
        run_stream(MOORE_OV,  14'b01_0101_0101_0000, "moore_ov");
        run_stream(MOORE_NOV, 14'b01_0001_0001_0000, "moore_nov");
        // Mealy: high while the final 1 is presented.
        run_stream(MEALY_OV,  14'b00_1010_1010_1000, "mealy_ov");
        run_stream(MEALY_NOV, 14'b00_1000_1000_1000, "mealy_nov");

        // Mode change mid-pattern discards the seen "10".
        step(1'b0, MOORE_OV, 1'b0, "mchg_reset", 1'b0);
        step(1'b1, MOORE_OV, 1'b1, "mchg_b1", 1'b0);
        step(1'b1, MOORE_OV, 1'b0, "mchg_b0", 1'b0);
        step(1'b1, MEALY_OV, 1'b1, "mchg_switch_b1", 1'b0);
        step(1'b1, MEALY_OV, 1'b0, "mchg_after0", 1'b0);
        step(1'b1, MEALY_OV, 1'b1, "mchg_after1", 1'b0);
        step(1'b1, MEALY_OV, 1'b0, "mchg_fresh0", 1'b0);
        step(1'b1, MEALY_OV, 1'b1, "mchg_fresh1", 1'b1);

        // Sitting in S101 when a Mealy mode is selected gives no detection.
        step(1'b0, MOORE_OV, 1'b0, "s101_reset", 1'b0);
        step(1'b1, MOORE_OV, 1'b1, "s101_b1", 1'b0);
        step(1'b1, MOORE_OV, 1'b0, "s101_b0", 1'b0);
        step(1'b1, MOORE_OV, 1'b1, "s101_b1b", 1'b0);
        step(1'b1, MEALY_NOV, 1'b0, "s101_mealy", 1'b0);
        step(1'b1, MEALY_NOV, 1'b1, "s101_next", 1'b0);

        // Reset mid-pattern in a Mealy mode: forced low during reset, history lost.
        step(1'b0, MEALY_OV, 1'b0, "rst_reset", 1'b0);
        step(1'b1, MEALY_OV, 1'b1, "rst_b1", 1'b0);
        step(1'b1, MEALY_OV, 1'b0, "rst_b0", 1'b0);
        step(1'b0, MEALY_OV, 1'b1, "rst_during_d1", 1'b0);
        step(1'b1, MEALY_OV, 1'b1, "rst_release_b1", 1'b0);
        step(1'b1, MEALY_OV, 1'b0, "rst_new_b0", 1'b0);
        step(1'b1, MEALY_OV, 1'b1, "rst_new_b1", 1'b1);

        // Same in a Moore mode.
        step(1'b0, MOORE_NOV, 1'b0, "mrst_reset", 1'b0);
        step(1'b1, MOORE_NOV, 1'b1, "mrst_b1", 1'b0);
        step(1'b1, MOORE_NOV, 1'b0, "mrst_b0", 1'b0);
        step(1'b0, MOORE_NOV, 1'b1, "mrst_during_d1", 1'b0);
        step(1'b1, MOORE_NOV, 1'b1, "mrst_release_b1", 1'b0);
        step(1'b1, MOORE_NOV, 1'b0, "mrst_after", 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/sequence_detector_101.md
SEQUENCE_DETECTOR_101 -- requirements
Module: sequence_detector_101

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port data, input, 1 bit: serial bit stream, one bit sampled per rising clk edge.
REQ-004 SHALL have port mode, input, 2 bits: 00 Moore overlap; 01 Moore non-overlap; 10 Mealy overlap; 11 Mealy non-overlap.
REQ-005 SHALL have port detected, output, 1 bit: high when pattern 1-0-1 is recognised.
REQ-006 SHALL have no parameters; the pattern is fixed at 101.

Function
REQ-007 SHALL use one 2-bit state register encoded S0=00 (idle), S1=01 (seen 1), S10=10 (seen 10), S101=11 (seen 101, Moore modes only).
REQ-008 Common transitions: S0: 1->S1, 0->S0; S1: 1->S1, 0->S10.
REQ-009 Moore modes, S10: 1->S101, 0->S0.
REQ-010 Mode 00 (Moore overlap), S101: 1->S1, 0->S10.
REQ-011 Mode 01 (Moore non-overlap), S101: 1->S1, 0->S0.
REQ-012 Moore output SHALL be detected = (state==S101): high for exactly one cycle, starting the cycle after the edge that samples the final 1.
REQ-013 Mealy modes SHALL never enter S101; S10: 1->S1 in mode 10, 1->S0 in mode 11; S10: 0->S0 in both modes.
REQ-014 Mealy output SHALL be combinational: detected = (state==S10) && data, valid in the same cycle the final 1 is presented.
REQ-015 If the FSM is in S101 while a Mealy mode is selected, the next state SHALL be S0 and detected SHALL be 0.
REQ-016 A registered copy mode_q SHALL be updated every edge; when mode != mode_q the next state SHALL be S0 regardless of data, so pattern history is discarded on a mode change.
REQ-017 A mode change SHALL take effect at the next edge; no glitch protection on detected is required beyond the gating in REQ-019.

Reset
REQ-018 On a rising clk edge with rst=0: state<=S0 and mode_q<=mode.
REQ-019 While rst=0, detected SHALL be forced to 0 combinationally, including in Mealy modes.
REQ-020 Reset asserted mid-sequence SHALL discard any partial match; after release, detection SHALL require a complete new 1-0-1.

Structure
REQ-021 A shared package SHALL hold the state encoding constants (S0, S1, S10, S101) and the mode constants (MOORE_OV, MOORE_NOV, MEALY_OV, MEALY_NOV).
REQ-022 SHALL be implemented as a single module: one sequential block (state, mode_q), one next-state block and one output block; no sub-module is required.

Verification
REQ-023 Mode 00: after reset, drive 1,0,1,0,1,0,1,0,1,0,1 then 0,0 -> detected pulses 5 times, one cycle each, the cycle after bits 3,5,7,9,11 are sampled.
REQ-024 Mode 01: same stream -> detected pulses 3 times, after bits 3, 7 and 11; no pulse after bits 5 or 9.
REQ-025 Mode 10: same stream -> detected high during the cycles presenting bits 3,5,7,9,11 (5 pulses), combinationally with data.
REQ-026 Mode 11: same stream -> detected high while bits 3, 7 and 11 are presented (3 pulses).
REQ-027 Mode 00: drive 1,0, then switch mode to 10 and drive 1 -> no detection, because the mode change resets the state to S0.
REQ-028 Any mode: drive 1,0, assert rst=0 for one edge, release, drive 1 -> detected remains 0 throughout, and stays 0 during reset even with data=1.
